// File: rtl/cell_draw_sequencer.sv
// Turns a changed grid cell (x, y, obj_code) into the LCD byte stream:
// column/page address set, memory write, then CELL_PX*CELL_PX RGB565 pixels.
//
// state | meaning
// IDLE  | waiting for a start pulse from the scanner
// HDR   | sending the 11 address/command header bytes
// PIX   | sending pixel bytes, hi then lo per pixel
// DONE  | one-cycle cmd_done pulse, then back to IDLE
module cell_draw_sequencer #(
  parameter int CELL_PX = 20,
  parameter int GRID_H  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_dcx,
  output logic       busy,
  output logic       cmd_done
);

  localparam int NPIX = CELL_PX * CELL_PX;
  localparam int PW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, HDR, PIX, DONE} state_t;

  state_t        state;
  logic [3:0]    x_lat;
  logic [3:0]    y_lat;
  logic [15:0]   color;
  logic [3:0]    hdr_idx;
  logic [PW-1:0] pix_cnt;
  logic          phase_lo;

  logic [15:0] x0, x1, y0, y1;
  logic [8:0]  nxt_hdr;

  assign x0 = 16'(x_lat) * 16'(CELL_PX);
  assign x1 = x0 + 16'(CELL_PX - 1);
  assign y0 = 16'(y_lat) * 16'(CELL_PX);
  assign y1 = y0 + 16'(CELL_PX - 1);

  function automatic logic [15:0] code_color(input logic [2:0] c);
    case (c)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h07E0;
      3'd2:    return 16'h03E0;
      3'd3:    return 16'hF800;
      3'd4:    return 16'hFFFF;
      default: return 16'hF81F;
    endcase
  endfunction

  // {dcx, data} of the header byte that follows the one currently presented
  always_comb begin
    nxt_hdr = {1'b0, 8'h2A};
    case (hdr_idx + 4'd1)
      4'd1:    nxt_hdr = {1'b1, x0[15:8]};
      4'd2:    nxt_hdr = {1'b1, x0[7:0]};
      4'd3:    nxt_hdr = {1'b1, x1[15:8]};
      4'd4:    nxt_hdr = {1'b1, x1[7:0]};
      4'd5:    nxt_hdr = {1'b0, 8'h2B};
      4'd6:    nxt_hdr = {1'b1, y0[15:8]};
      4'd7:    nxt_hdr = {1'b1, y0[7:0]};
      4'd8:    nxt_hdr = {1'b1, y1[15:8]};
      4'd9:    nxt_hdr = {1'b1, y1[7:0]};
      4'd10:   nxt_hdr = {1'b0, 8'h2C};
      default: nxt_hdr = {1'b0, 8'h2A};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_lat     <= '0;
      y_lat     <= '0;
      color     <= '0;
      hdr_idx   <= '0;
      pix_cnt   <= '0;
      phase_lo  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_dcx   <= 1'b0;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_lat    <= x;
            y_lat    <= y;
            color    <= code_color(obj_code);
            hdr_idx  <= '0;
            pix_cnt  <= '0;
            phase_lo <= 1'b0;
            busy     <= 1'b1;
            if (int'(y) >= GRID_H) begin
              state    <= DONE;
              cmd_done <= 1'b1;
            end else begin
              state     <= HDR;
              out_valid <= 1'b1;
              out_data  <= 8'h2A;
              out_dcx   <= 1'b0;
            end
          end
        end
        HDR: begin
          if (out_ready) begin
            if (hdr_idx == 4'd10) begin
              state    <= PIX;
              phase_lo <= 1'b0;
              out_data <= color[15:8];
              out_dcx  <= 1'b1;
            end else begin
              hdr_idx              <= hdr_idx + 4'd1;
              {out_dcx, out_data}  <= nxt_hdr;
            end
          end
        end
        PIX: begin
          if (out_ready) begin
            if (!phase_lo) begin
              phase_lo <= 1'b1;
              out_data <= color[7:0];
            end else if (pix_cnt == PW'(NPIX - 1)) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              out_dcx   <= 1'b0;
              cmd_done  <= 1'b1;
            end else begin
              pix_cnt  <= pix_cnt + 1'b1;
              phase_lo <= 1'b0;
              out_data <= color[15:8];
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          cmd_done <= 1'b0;
          busy     <= 1'b0;
          hdr_idx  <= '0;
          pix_cnt  <= '0;
          phase_lo <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_draw_sequencer.sv
// Scoreboard bench for cell_draw_sequencer: a reference model queues the
// expected byte stream per request and a monitor pops it on each handshake.
module tb_cell_draw_sequencer;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [2:0] obj_code = '0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_dcx;
  logic       busy;
  logic       cmd_done;

  int checks = 0;
  int errors = 0;
  int got_done = 0;
  int rand_ready = 0;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;

  cell_draw_sequencer dut (
    .clk(tb_clk), .rst(rst), .start(start), .x(x), .y(y), .obj_code(obj_code),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_dcx(out_dcx), .busy(busy), .cmd_done(cmd_done)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) begin
    #1;
    out_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected {dcx, data} bytes for one request
  task automatic push_expected(input int xv, input int yv, input int code);
    int cmap[8] = '{'h0000, 'h07E0, 'h03E0, 'hF800, 'hFFFF, 'hF81F, 'hF81F, 'hF81F};
    int x0, x1, y0, y1, c;
    if (yv >= 12) return;
    x0 = xv * 20; x1 = x0 + 19;
    y0 = yv * 20; y1 = y0 + 19;
    c = cmap[code];
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(x0 >> 8)}); exp_q.push_back({1'b1, 8'(x0)});
    exp_q.push_back({1'b1, 8'(x1 >> 8)}); exp_q.push_back({1'b1, 8'(x1)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(y0 >> 8)}); exp_q.push_back({1'b1, 8'(y0)});
    exp_q.push_back({1'b1, 8'(y1 >> 8)}); exp_q.push_back({1'b1, 8'(y1)});
    exp_q.push_back({1'b0, 8'h2C});
    for (int i = 0; i < 400; i++) begin
      exp_q.push_back({1'b1, 8'(c >> 8)});
      exp_q.push_back({1'b1, 8'(c)});
    end
  endtask

  always @(negedge tb_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_byte", int'({out_dcx, out_data}), int'(prev_byte));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte got %0h expected none at %0t", {out_dcx, out_data}, $time);
        end else begin
          chk("stream_byte", int'({out_dcx, out_data}), int'(exp_q.pop_front()));
        end
      end
      if (cmd_done) begin
        got_done++;
        chk("done_after_last", exp_q.size(), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = {out_dcx, out_data};
    end
  end

  // Entered and left at 1 ns after a rising edge
  task automatic draw(input int xv, input int yv, input int code, input int rmode,
                      input int busy_start_at, input int abort_at, input int exp_lat);
    int cnt, d0;
    bit seen;
    rand_ready = rmode;
    x = 4'(xv); y = 4'(yv); obj_code = 3'(code);
    start = 1'b1;
    push_expected(xv, yv, code);
    d0 = got_done;
    @(posedge tb_clk); #1;
    start = 1'b0;
    x = 4'($urandom); y = 4'($urandom); obj_code = 3'($urandom);
    chk("busy_after_start", int'(busy), 1);
    chk("valid_after_start", int'(out_valid), (yv < 12) ? 1 : 0);
    cnt = 0; seen = 0;
    while (!seen && cnt < 6000) begin
      if (cmd_done) begin
        seen = 1;
      end else begin
        start = (cnt == busy_start_at);
        if (cnt == busy_start_at) begin
          x = 4'(xv ^ 5); y = 4'((yv + 3) % 12); obj_code = 3'(code + 1);
        end
        if (cnt == abort_at) begin
          #1 rst = 1'b1;
          #1;
          chk("rst_valid", int'(out_valid), 0);
          chk("rst_data", int'(out_data), 0);
          chk("rst_dcx", int'(out_dcx), 0);
          chk("rst_busy", int'(busy), 0);
          chk("rst_done", int'(cmd_done), 0);
          exp_q.delete();
          @(posedge tb_clk); #1;
          rst = 1'b0;
          rand_ready = 0;
          chk("abort_no_done", got_done - d0, 0);
          return;
        end
        @(posedge tb_clk); #1;
        cnt++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout got none expected cmd_done at %0t", $time);
      return;
    end
    if (exp_lat >= 0) chk("done_latency", cnt, exp_lat);
    @(posedge tb_clk); #1;
    chk("busy_cleared", int'(busy), 0);
    chk("done_one_cycle", int'(cmd_done), 0);
    chk("done_count", got_done - d0, 1);
    chk("stream_complete", exp_q.size(), 0);
    rand_ready = 0;
  endtask

  initial begin
    repeat (3) @(posedge tb_clk);
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_dcx", int'(out_dcx), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(cmd_done), 0);
    rst = 1'b0;
    @(posedge tb_clk); #1;

    draw(0, 0, 4, 0, -1, -1, 811);
    draw(15, 11, 3, 0, -1, -1, 811);
    draw(15, 11, 3, 1, -1, -1, -1);
    draw(2, 12, 1, 0, -1, -1, 0);
    draw(5, 5, 2, 0, 50, -1, 811);
    draw(9, 7, 2, 0, 500, -1, 811);
    draw(7, 3, 0, 0, -1, 300, -1);
    draw(7, 3, 0, 0, -1, -1, 811);

    #2 rst = 1'b1;
    #1;
    chk("idle_rst_valid", int'(out_valid), 0);
    chk("idle_rst_busy", int'(busy), 0);
    chk("idle_rst_done", int'(cmd_done), 0);
    @(posedge tb_clk); #1;
    rst = 1'b0;
    @(posedge tb_clk); #1;

    for (int i = 0; i < 6; i++) begin
      int xv, yv, cv, rm, lat;
      xv = $urandom_range(0, 15);
      yv = $urandom_range(0, 13);
      cv = $urandom_range(0, 7);
      rm = $urandom_range(0, 1);
      lat = (yv >= 12) ? 0 : ((rm == 0) ? 811 : -1);
      draw(xv, yv, cv, rm, $urandom_range(1, 200), -1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
